mult_cell_arbiter: RTL

- Shares one pipelined 32-bit multiply cell between NUM_REQ requesters; the cell has unregistered inputs, one internal product register, and a free-running enable.
- Round-robin grant with a valid/ready request handshake per requester.
- Operands are registered into the cell. A tag pipeline tracks the owner of each product.
- Products land in a response FIFO. Credit-based issue means the non-stallable cell never overruns that FIFO.

---
 rtl/mult_cell_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mult_cell_arbiter.sv
// Round-robin front end that shares one pipelined multiply cell between several requesters.
// Issue is credit-limited so the non-stallable cell can never overrun the response FIFO.
module mult_cell_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int IDW        = 1,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_src1,
  input  logic [32*NUM_REQ-1:0]   req_src2,
  output logic [31:0]             mul_src1,
  output logic [31:0]             mul_src2,
  input  logic [31:0]             mul_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(LATENCY + FIFO_DEPTH + 2);

  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [31:0]    src1_q, src1_d, src2_q, src2_d;
  logic [LATENCY:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0] tag_id_q [LATENCY+1];
  logic [IDW-1:0] fifo_id_q [FIFO_DEPTH];
  logic [31:0]    fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [OW-1:0]  outstanding;
  logic           issue_ok, found, hs, push, pop;
  logic [IDW-1:0] grant_id;
  int             idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ops in the tag pipeline already own a FIFO slot, so they count as credit in use.
  always_comb begin
    outstanding = OW'(count_q);
    for (int s = 0; s <= LATENCY; s++) begin
      outstanding = outstanding + OW'(tag_vld_q[s]);
    end
  end

  assign issue_ok = !reset && (outstanding < OW'(FIFO_DEPTH));

  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found          = 1'b1;
        grant_id       = IDW'(idx);
        req_ready[idx] = issue_ok;
      end
    end
  end

  assign hs = |(req_valid & req_ready);

  always_comb begin
    last_grant_d = last_grant_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    if (hs) begin
      last_grant_d = grant_id;
      src1_d       = req_src1[32*int'(grant_id) +: 32];
      src2_d       = req_src2[32*int'(grant_id) +: 32];
    end
  end

  assign tag_vld_d = {tag_vld_q[LATENCY-1:0], hs};
  assign push      = tag_vld_q[LATENCY];
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IDW'(NUM_REQ - 1);
      src1_q       <= '0;
      src2_q       <= '0;
      tag_vld_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int s = 0; s <= LATENCY; s++) tag_id_q[s] <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        fifo_id_q[e]   <= '0;
        fifo_data_q[e] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      tag_vld_q    <= tag_vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tag_id_q[0]  <= grant_id;
      for (int s = 1; s <= LATENCY; s++) tag_id_q[s] <= tag_id_q[s-1];
      if (push) begin
        fifo_id_q[wr_ptr_q]   <= tag_id_q[LATENCY];
        fifo_data_q[wr_ptr_q] <= mul_result;
      end
    end
  end

  assign mul_src1 = src1_q;
  assign mul_src2 = src2_q;
  assign rsp_id   = rsp_valid ? fifo_id_q[rd_ptr_q]   : '0;
  assign rsp_data = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign busy     = (outstanding != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule
